// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster timing with a divided pixel enable and zero-skew decode.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
   parameter int unsigned PIX_DIV     = 4,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACT_END   = 784,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_ACT_START = 35,
   parameter int unsigned V_ACT_END   = 515
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        pix_en,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        hSync,
   output logic        vSync,
   output logic        bright,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int unsigned DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h;
   logic [9:0]       r_v;
   logic             r_hs;
   logic             r_vs;
   logic             r_br;
   logic             r_ls;
   logic             r_fs;
   logic [9:0]       w_h_nxt;
   logic [9:0]       w_v_nxt;
   logic             w_h_wrap;
   logic             w_v_wrap;

   assign pix_en = reset_n && (r_div == DIV_LAST);

   always_comb begin
      w_h_wrap = (r_h == 10'(H_TOTAL - 1));
      w_v_wrap = (r_v == 10'(V_TOTAL - 1));
      w_h_nxt  = r_h;
      w_v_nxt  = r_v;
      if (pix_en) begin
         if (w_h_wrap) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_wrap ? '0 : r_v + 10'd1;
         end else begin
            w_h_nxt = r_h + 10'd1;
         end
      end
   end

   // Decode from next-state counters so sync/bright line up with the counters they describe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b0;
         r_br  <= 1'b0;
         r_ls  <= 1'b0;
         r_fs  <= 1'b0;
      end else begin
         r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
         r_h   <= w_h_nxt;
         r_v   <= w_v_nxt;
         r_hs  <= (w_h_nxt >= 10'(H_SYNC));
         r_vs  <= (w_v_nxt >= 10'(V_SYNC));
         r_br  <= (w_h_nxt >= 10'(H_ACT_START)) && (w_h_nxt < 10'(H_ACT_END)) &&
                  (w_v_nxt >= 10'(V_ACT_START)) && (w_v_nxt < 10'(V_ACT_END));
         r_ls  <= pix_en && w_h_wrap;
         r_fs  <= pix_en && w_h_wrap && w_v_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] r_fc;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fc <= '0;
      end else if (pix_en && w_h_wrap && w_v_wrap) begin
         r_fc <= r_fc + 16'd1;
      end
   end

   assign frame_count = r_fc;
`endif

   assign hCount      = r_h;
   assign vCount      = r_v;
   assign hSync       = r_hs;
   assign vSync       = r_vs;
   assign bright      = r_br;
   assign line_start  = r_ls;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
// Reference model derives every output from the number of clocks since reset release.
module tb_vga_timing_gen;

   localparam int unsigned PD  = 4;
   localparam int unsigned HT  = 48;
   localparam int unsigned HS  = 6;
   localparam int unsigned HAS = 9;
   localparam int unsigned HAE = 44;
   localparam int unsigned VT  = 22;
   localparam int unsigned VS  = 2;
   localparam int unsigned VAS = 4;
   localparam int unsigned VAE = 19;
   localparam int unsigned FRAME_CLKS = PD * HT * VT;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pix_en;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        hSync;
   logic        vSync;
   logic        bright;
   logic        line_start;
   logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   int          total = 0;
   int          bad = 0;
   int unsigned k = 0;  // clock edges since the last edge that saw reset_n low

   vga_timing_gen #(
      .PIX_DIV(PD), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
      .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pix_en      (pix_en),
      .hCount      (hCount),
      .vCount      (vCount),
      .hSync       (hSync),
      .vSync       (vSync),
      .bright      (bright),
      .line_start  (line_start),
      .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   always #5 clk = ~clk;

   logic [24:0] w_act;
   assign w_act = {pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start};

   function automatic logic [24:0] model(input int unsigned kk, input logic rn);
      int unsigned p, h, v;
      logic        wrap;
      p    = kk / PD;
      h    = p % HT;
      v    = (p / HT) % VT;
      wrap = (kk % PD == 0) && (p > 0) && (h == 0);
      model = {rn && (kk % PD == PD - 1), 10'(h), 10'(v), (h >= HS), (v >= VS),
               (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE), wrap, wrap && (v == 0)};
   endfunction

   function automatic logic [15:0] model_frames(input int unsigned kk);
      model_frames = 16'((kk / PD) / (HT * VT));
   endfunction

   function automatic int unsigned model_hv(input int unsigned kk);
      model_hv = (kk / PD) % (HT * VT);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!reset_n) k = 0;
      else k++;
      @(negedge clk);
   endtask

   task automatic test_scan(input int unsigned n, input string name);
      for (int i = 0; i < n; i++) begin
         tick();
         total++;
         if (w_act !== model(k, reset_n)) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", name, k, w_act, model(k, reset_n));
         end
`ifdef VGA_FRAME_CNT_EN
         total++;
         if (frame_count !== model_frames(k)) begin
            bad++;
            $display("FAIL %s_fcnt k=%0d got=%0d want=%0d", name, k, frame_count,
                     model_frames(k));
         end
`endif
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (w_act !== 25'd0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%h want=0", i, w_act);
         end
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({pix_en, hCount} !== 11'd0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%h want=0", i, {pix_en, hCount});
         end
         tick();
      end
      total++;
      if ({pix_en, hCount} !== {1'b1, 10'd0}) begin
         bad++;
         $display("FAIL first_pix_en got=%h want=%h", {pix_en, hCount}, {1'b1, 10'd0});
      end
      tick();
      total++;
      if ({hCount, vCount, hSync} !== {10'd1, 10'd0, 1'b0}) begin
         bad++;
         $display("FAIL first_pixel got=%0d,%0d,%b want=1,0,0", hCount, vCount, hSync);
      end
   endtask

   typedef struct {
      int unsigned h;
      int unsigned v;
      logic [2:0]  exp;  // {bright, hSync, vSync}
   } point_t;

   task automatic test_points();
      point_t pts[10];
      pts[0] = '{5, 0, 3'b000};
      pts[1] = '{6, 0, 3'b010};
      pts[2] = '{6, 1, 3'b010};
      pts[3] = '{6, 2, 3'b011};
      pts[4] = '{9, 3, 3'b011};
      pts[5] = '{8, 4, 3'b011};
      pts[6] = '{9, 4, 3'b111};
      pts[7] = '{43, 18, 3'b111};
      pts[8] = '{44, 18, 3'b011};
      pts[9] = '{9, 19, 3'b011};
      for (int i = 0; i < 10; i++) begin
         int unsigned budget;
         budget = FRAME_CLKS + 8;
         while (model_hv(k) != pts[i].v * HT + pts[i].h && budget > 0) begin
            tick();
            budget--;
         end
         total++;
         if ({hCount, vCount} !== {10'(pts[i].h), 10'(pts[i].v)} ||
             {bright, hSync, vSync} !== pts[i].exp) begin
            bad++;
            $display("FAIL point(%0d,%0d) got=(%0d,%0d) bhv=%b want=%b", pts[i].h, pts[i].v,
                     hCount, vCount, {bright, hSync, vSync}, pts[i].exp);
         end
      end
   endtask

   task automatic test_frame_period();
      int unsigned c;
      c = 0;
      while (frame_start !== 1'b1 && c < 2 * FRAME_CLKS) begin
         tick();
         c++;
      end
      total++;
      if ({frame_start, line_start, vSync, hCount, vCount} !== {3'b110, 20'd0}) begin
         bad++;
         $display("FAIL frame_wrap got=%b,%b,%b,%0d,%0d want=1,1,0,0,0", frame_start,
                  line_start, vSync, hCount, vCount);
      end
      c = 0;
      do begin
         tick();
         c++;
      end while (frame_start !== 1'b1 && c < 2 * FRAME_CLKS);
      total++;
      if (c !== FRAME_CLKS) begin
         bad++;
         $display("FAIL frame_period got=%0d want=%0d", c, FRAME_CLKS);
      end
      tick();
      total++;
      if ({frame_start, line_start} !== 2'b00) begin
         bad++;
         $display("FAIL pulse_width got=%b want=00", {frame_start, line_start});
      end
   endtask

   task automatic test_mid_reset(input int unsigned h, input int unsigned v);
      int unsigned budget;
      budget = FRAME_CLKS + 8;
      while (model_hv(k) != v * HT + h && budget > 0) begin
         tick();
         budget--;
      end
      reset_n = 1'b0;
      tick();
      total++;
      if (w_act !== 25'd0) begin
         bad++;
         $display("FAIL mid_reset(%0d,%0d) got=%h want=0", h, v, w_act);
      end
      reset_n = 1'b1;
      test_scan(600, "after_reset");
   endtask

   task automatic test_random_reset();
      for (int i = 0; i < 4; i++) begin
         test_scan($urandom_range(1, 3000), "rand_run");
         reset_n = 1'b0;
         test_scan($urandom_range(1, 3), "rand_reset");
         reset_n = 1'b1;
         test_scan(200, "rand_restart");
      end
   endtask

   initial begin
      test_reset();
      test_scan(FRAME_CLKS + 500, "scan");
      test_points();
      test_frame_period();
      test_mid_reset(20, 12);
      test_random_reset();
      test_scan(2 * FRAME_CLKS + 100, "two_frames");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
